id_ex_hazard_stage: RTL and testbench



---
 rtl/id_ex_hazard_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS pipeline.
// Captures decoded operands and control from ID, stalls PC and IF/ID when a
// load result is needed too early, inserts bubbles on stall/flush, and keeps
// a saturating debug count of stall cycles.
module id_ex_hazard_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic          id_regWrite,
    input  logic          id_memRead,
    input  logic          id_memWrite,
    input  logic          id_memToReg,
    input  logic          id_aluSrc,
    input  logic          id_regDst,
    input  logic [3:0]    id_aluOp,
    output logic          ex_valid,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic          ex_regWrite,
    output logic          ex_memRead,
    output logic          ex_memWrite,
    output logic          ex_memToReg,
    output logic          ex_aluSrc,
    output logic          ex_regDst,
    output logic [3:0]    ex_aluOp,
    output logic          stall,
    output logic [CW-1:0] stall_cnt
);

    logic          ex_valid_q,    ex_valid_d;
    logic [AW-1:0] ex_rs_q,       ex_rs_d;
    logic [AW-1:0] ex_rt_q,       ex_rt_d;
    logic [AW-1:0] ex_rd_q,       ex_rd_d;
    logic [DW-1:0] ex_rdata1_q,   ex_rdata1_d;
    logic [DW-1:0] ex_rdata2_q,   ex_rdata2_d;
    logic [DW-1:0] ex_imm_q,      ex_imm_d;
    logic          ex_regWrite_q, ex_regWrite_d;
    logic          ex_memRead_q,  ex_memRead_d;
    logic          ex_memWrite_q, ex_memWrite_d;
    logic          ex_memToReg_q, ex_memToReg_d;
    logic          ex_aluSrc_q,   ex_aluSrc_d;
    logic          ex_regDst_q,   ex_regDst_d;
    logic [3:0]    ex_aluOp_q,    ex_aluOp_d;
    logic [CW-1:0] stall_cnt_q,   stall_cnt_d;

    logic load_use;
    logic rs_match;
    logic rt_match;

    // Hazard detection: a load in EX writing a nonzero register that the ID instruction reads.
    // Reset clears ex_valid_q, so stall falls to 0 as soon as reset asserts.
    always_comb begin
        rs_match = id_uses_rs & (id_rs == ex_rt_q);
        rt_match = id_uses_rt & (id_rt == ex_rt_q);
        load_use = ex_valid_q & ex_memRead_q & ex_regWrite_q & (ex_rt_q != '0) &
                   id_valid & (rs_match | rt_match);
        stall    = load_use & ~flush & ~hold;
    end

    // Next-state for the pipeline register: hold > flush > stall bubble > normal load.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_rd_d       = ex_rd_q;
        ex_rdata1_d   = ex_rdata1_q;
        ex_rdata2_d   = ex_rdata2_q;
        ex_imm_d      = ex_imm_q;
        ex_regWrite_d = ex_regWrite_q;
        ex_memRead_d  = ex_memRead_q;
        ex_memWrite_d = ex_memWrite_q;
        ex_memToReg_d = ex_memToReg_q;
        ex_aluSrc_d   = ex_aluSrc_q;
        ex_regDst_d   = ex_regDst_q;
        ex_aluOp_d    = ex_aluOp_q;
        if (!hold) begin
            ex_rs_d       = id_rs;
            ex_rt_d       = id_rt;
            ex_rd_d       = id_rd;
            ex_rdata1_d   = id_rdata1;
            ex_rdata2_d   = id_rdata2;
            ex_imm_d      = id_imm;
            ex_aluSrc_d   = id_aluSrc;
            ex_regDst_d   = id_regDst;
            ex_aluOp_d    = id_aluOp;
            if (flush || stall || !id_valid) begin
                // A bubble must never write a register or memory, so all enables drop.
                ex_valid_d    = 1'b0;
                ex_regWrite_d = 1'b0;
                ex_memRead_d  = 1'b0;
                ex_memWrite_d = 1'b0;
                ex_memToReg_d = 1'b0;
            end else begin
                ex_valid_d    = 1'b1;
                ex_regWrite_d = id_regWrite;
                ex_memRead_d  = id_memRead;
                ex_memWrite_d = id_memWrite;
                ex_memToReg_d = id_memToReg;
            end
        end
    end

    // Stall counter: counts cycles where a load-use stall is issued, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_rdata1_q   <= '0;
            ex_rdata2_q   <= '0;
            ex_imm_q      <= '0;
            ex_regWrite_q <= 1'b0;
            ex_memRead_q  <= 1'b0;
            ex_memWrite_q <= 1'b0;
            ex_memToReg_q <= 1'b0;
            ex_aluSrc_q   <= 1'b0;
            ex_regDst_q   <= 1'b0;
            ex_aluOp_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_rdata1_q   <= ex_rdata1_d;
            ex_rdata2_q   <= ex_rdata2_d;
            ex_imm_q      <= ex_imm_d;
            ex_regWrite_q <= ex_regWrite_d;
            ex_memRead_q  <= ex_memRead_d;
            ex_memWrite_q <= ex_memWrite_d;
            ex_memToReg_q <= ex_memToReg_d;
            ex_aluSrc_q   <= ex_aluSrc_d;
            ex_regDst_q   <= ex_regDst_d;
            ex_aluOp_q    <= ex_aluOp_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_rdata1   = ex_rdata1_q;
    assign ex_rdata2   = ex_rdata2_q;
    assign ex_imm      = ex_imm_q;
    assign ex_regWrite = ex_regWrite_q;
    assign ex_memRead  = ex_memRead_q;
    assign ex_memWrite = ex_memWrite_q;
    assign ex_memToReg = ex_memToReg_q;
    assign ex_aluSrc   = ex_aluSrc_q;
    assign ex_regDst   = ex_regDst_q;
    assign ex_aluOp    = ex_aluOp_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Testbench for id_ex_hazard_stage: directed hazard scenarios plus random traffic,
// checked by a scoreboard fed from an instruction-level reference model.
module tb_id_ex_hazard_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold, flush, id_valid;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;
    logic          id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
    logic [3:0]    id_aluOp;
    logic          ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic          ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_regDst;
    logic [3:0]    ex_aluOp;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    // One ID-stage instruction plus the global hold/flush controls for that cycle.
    typedef struct {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic          uses_rs, uses_rt;
        logic [DW-1:0] r1, r2, imm;
        logic          regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [3:0]    aluOp;
        logic          hold, flush;
    } stim_t;

    // The instruction occupying EX, the stall decision for the cycle, and the counter.
    typedef struct {
        logic          stall;
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] r1, r2, imm;
        logic          regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
        logic [3:0]    aluOp;
        int            cnt;
    } exp_t;

    exp_t expQ[$];
    exp_t model;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
        .id_aluOp(id_aluOp),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst),
        .ex_aluOp(ex_aluOp), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic stim_t mkInstr(bit v, int rs, int rt, int rd, bit urs, bit urt,
                                      bit mr, bit rw, bit mw);
        stim_t s;
        s.valid = v;       s.rs = AW'(rs);   s.rt = AW'(rt);   s.rd = AW'(rd);
        s.uses_rs = urs;   s.uses_rt = urt;
        s.r1 = $urandom;   s.r2 = $urandom;  s.imm = $urandom;
        s.memRead = mr;    s.regWrite = rw;  s.memWrite = mw;  s.memToReg = mr;
        s.aluSrc = 1'($urandom_range(0, 1));
        s.regDst = 1'($urandom_range(0, 1));
        s.aluOp = 4'($urandom_range(0, 15));
        s.hold = 1'b0;     s.flush = 1'b0;
        return s;
    endfunction

    // Drives one cycle of ID inputs and predicts the stall decision and the resulting EX contents.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   exIsLoad, idReadsIt;
        @(negedge clk);
        hold = s.hold;         flush = s.flush;       id_valid = s.valid;
        id_rs = s.rs;          id_rt = s.rt;          id_rd = s.rd;
        id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
        id_rdata1 = s.r1;      id_rdata2 = s.r2;      id_imm = s.imm;
        id_regWrite = s.regWrite; id_memRead = s.memRead; id_memWrite = s.memWrite;
        id_memToReg = s.memToReg; id_aluSrc = s.aluSrc;   id_regDst = s.regDst;
        id_aluOp = s.aluOp;
        #1;
        exIsLoad  = model.valid && model.memRead && model.regWrite && (model.rt != 0);
        idReadsIt = s.valid && ((s.uses_rs && s.rs == model.rt) || (s.uses_rt && s.rt == model.rt));
        e = model;
        e.stall = exIsLoad && idReadsIt && !s.flush && !s.hold;
        if (s.hold) begin
            e.stall = 1'b0;
        end else if (s.flush || e.stall) begin
            e.valid = 1'b0; e.regWrite = 1'b0; e.memRead = 1'b0; e.memWrite = 1'b0;
            if (e.stall && e.cnt < CNT_MAX) e.cnt = e.cnt + 1;
        end else begin
            e.valid = s.valid;
            e.rs = s.rs; e.rt = s.rt; e.rd = s.rd;
            e.r1 = s.r1; e.r2 = s.r2; e.imm = s.imm;
            e.regWrite = s.valid && s.regWrite;
            e.memRead  = s.valid && s.memRead;
            e.memWrite = s.valid && s.memWrite;
            e.memToReg = s.memToReg; e.aluSrc = s.aluSrc; e.regDst = s.regDst;
            e.aluOp = s.aluOp;
        end
        expQ.push_back(e);
        model = e;
    endtask

    // Monitor: samples stall mid-cycle, then compares the post-edge EX state to the scoreboard head.
    logic mStall;
    exp_t mExp;
    initial begin
        forever begin
            @(negedge clk);
            #3;
            mStall = stall;
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                mExp = expQ.pop_front();
                checkOutput("stall", 64'(mStall), 64'(mExp.stall));
                checkOutput("ex_valid", 64'(ex_valid), 64'(mExp.valid));
                checkOutput("ex_regWrite", 64'(ex_regWrite), 64'(mExp.regWrite));
                checkOutput("ex_memRead", 64'(ex_memRead), 64'(mExp.memRead));
                checkOutput("ex_memWrite", 64'(ex_memWrite), 64'(mExp.memWrite));
                checkOutput("stall_cnt", 64'(stall_cnt), 64'(mExp.cnt));
                if (mExp.valid) begin
                    checkOutput("ex_rs", 64'(ex_rs), 64'(mExp.rs));
                    checkOutput("ex_rt", 64'(ex_rt), 64'(mExp.rt));
                    checkOutput("ex_rd", 64'(ex_rd), 64'(mExp.rd));
                    checkOutput("ex_rdata1", 64'(ex_rdata1), 64'(mExp.r1));
                    checkOutput("ex_rdata2", 64'(ex_rdata2), 64'(mExp.r2));
                    checkOutput("ex_imm", 64'(ex_imm), 64'(mExp.imm));
                    checkOutput("ex_memToReg", 64'(ex_memToReg), 64'(mExp.memToReg));
                    checkOutput("ex_aluSrc", 64'(ex_aluSrc), 64'(mExp.aluSrc));
                    checkOutput("ex_regDst", 64'(ex_regDst), 64'(mExp.regDst));
                    checkOutput("ex_aluOp", 64'(ex_aluOp), 64'(mExp.aluOp));
                end
            end
        end
    end

    // Stimulus sequence: reset, directed hazard cases, async reset mid-run, random traffic.
    initial begin
        stim_t s;
        model = '{default: 0};
        s = mkInstr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        hold = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_regWrite = 0; id_memRead = 0; id_memWrite = 0; id_memToReg = 0;
        id_aluSrc = 0; id_regDst = 0; id_aluOp = 0;
        #2;
        checkOutput("reset_ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: lw $8 then add $9,$8,$3 stalls once, then the add loads.
        applyStimulus(mkInstr(1, 1, 8, 0, 1, 0, 1, 1, 0));
        applyStimulus(mkInstr(1, 8, 3, 9, 1, 1, 0, 1, 0));
        applyStimulus(mkInstr(1, 8, 3, 9, 1, 1, 0, 1, 0));
        @(posedge clk); #2;
        checkOutput("loaduse_cnt", 64'(stall_cnt), 64'd1);
        checkOutput("loaduse_rd", 64'(ex_rd), 64'd9);

        // No false stall: load into $0, and a store that does not read rt.
        applyStimulus(mkInstr(1, 1, 0, 0, 1, 0, 1, 1, 0));
        applyStimulus(mkInstr(1, 0, 0, 4, 1, 1, 0, 1, 0));
        applyStimulus(mkInstr(1, 1, 8, 0, 1, 0, 1, 1, 0));
        applyStimulus(mkInstr(1, 2, 8, 0, 1, 0, 0, 0, 1));

        // Flush beats a pending hazard: bubble, no stall, counter unchanged.
        applyStimulus(mkInstr(1, 1, 8, 0, 1, 0, 1, 1, 0));
        s = mkInstr(1, 8, 3, 9, 1, 1, 0, 1, 0);
        s.flush = 1'b1;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("flush_cnt", 64'(stall_cnt), 64'd1);

        // Hold for three cycles with a hazard present, then the stall happens once.
        applyStimulus(mkInstr(1, 1, 8, 0, 1, 0, 1, 1, 0));
        s = mkInstr(1, 8, 3, 9, 1, 1, 0, 1, 0);
        s.hold = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        s.hold = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("hold_cnt", 64'(stall_cnt), 64'd2);

        // Saturation: twenty load/dependent pairs drive the counter to its ceiling.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mkInstr(1, 1, 8, 0, 0, 0, 1, 1, 0));
            applyStimulus(mkInstr(1, 3, 8, 9, 0, 1, 0, 1, 0));
        end
        @(posedge clk); #2;
        checkOutput("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));

        // Asynchronous reset between clock edges while a valid load sits in EX.
        applyStimulus(mkInstr(1, 1, 8, 0, 1, 0, 1, 1, 0));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ex_valid", 64'(ex_valid), 64'd0);
        checkOutput("arst_regWrite", 64'(ex_regWrite), 64'd0);
        checkOutput("arst_memRead", 64'(ex_memRead), 64'd0);
        checkOutput("arst_rt", 64'(ex_rt), 64'd0);
        checkOutput("arst_rdata1", 64'(ex_rdata1), 64'd0);
        checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model = '{default: 0};

        // Random traffic over a small register range so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            s = mkInstr($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1));
            s.hold  = ($urandom_range(0, 9) == 0);
            s.flush = ($urandom_range(0, 9) == 0);
            applyStimulus(s);
        end

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboard_drain", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
